seq_signed_multiplier_p: RTL

Parametrised sequential signed multiplier, successor to the fixed 8-bit signed_multiplier. Owns its control internally: start/busy/done handshake and a 3-state FSM, replacing externally driven load/shift_en/reg_en/psel. Sign-magnitude shift-add core with a full-width two's-complement result, correct most-negative operand handling, and optional early termination. Sits between the operand source and the result consumer in the datapath.

---
 rtl/seq_signed_multiplier_p.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seq_signed_multiplier_p.sv
// seq_signed_multiplier_p
//   Sequential signed multiplier. Operand magnitudes are multiplied with a
//   shift-add loop that runs for one iteration per clock cycle. The sign is
//   applied once at the end, which gives a full-width two's-complement product.
//   A start/busy/done handshake and an IDLE/RUN/DONE FSM sequence the operation.
//
// Parameters
//   WIDTH       operand width in bits (>= 2)
//   EARLY_TERM  1 = stop as soon as the remaining multiplier magnitude is zero
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request; accepted only in IDLE or DONE
//   multiplier   signed operand, sampled on the accepting edge
//   multiplicand signed operand, sampled on the accepting edge
//   busy         high while the FSM is in RUN
//   done         one-cycle pulse; the results are valid from then on
//   product      signed product (2*WIDTH bits)
//   product_mag  unsigned magnitude of the product
//   sign         1 iff the product is negative
//   zflag        1 iff the product is zero
module seq_signed_multiplier_p #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_TERM = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   product_mag,
  output logic                 sign,
  output logic                 zflag
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 psign_q, psign_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   mag_q, mag_d;
  logic                 sign_q, sign_d;
  logic                 zflag_q, zflag_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     mplier_shift;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 res_load;
  logic                 res_psign;
  logic [2*WIDTH-1:0]   res_acc;

  // The two's-complement negation of the most-negative value wraps back to
  // 2^(WIDTH-1). Read as unsigned, that is exactly the required magnitude.
  assign mag_a        = multiplier[WIDTH-1]   ? (~multiplier + 1'b1)   : multiplier;
  assign mag_b        = multiplicand[WIDTH-1] ? (~multiplicand + 1'b1) : multiplicand;
  assign mplier_shift = mplier_q >> 1;
  assign acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    psign_d   = psign_q;
    product_d = product_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    zflag_d   = zflag_q;
    res_load  = 1'b0;
    res_psign = 1'b0;
    res_acc   = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mplier_d = mag_a;
          mcand_d  = {{WIDTH{1'b0}}, mag_b};
          acc_d    = '0;
          count_d  = '0;
          psign_d  = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
          if (EARLY_TERM && (mag_a == '0)) begin
            // A zero multiplier skips RUN. The results are written from the
            // cleared accumulator on this same edge.
            state_d   = S_DONE;
            res_load  = 1'b1;
            res_psign = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
            res_acc   = '0;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        count_d  = count_q + 1'b1;
        if ((count_q == LAST) || (EARLY_TERM && (mplier_shift == '0))) begin
          state_d   = S_DONE;
          res_load  = 1'b1;
          res_psign = psign_q;
          res_acc   = acc_sum;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (res_load) begin
      mag_d     = res_acc;
      zflag_d   = (res_acc == '0);
      sign_d    = res_psign & ~zflag_d;
      product_d = sign_d ? (~res_acc + 1'b1) : res_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      psign_q   <= 1'b0;
      product_q <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      zflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      psign_q   <= psign_d;
      product_q <= product_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      zflag_q   <= zflag_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign product     = product_q;
  assign product_mag = mag_q;
  assign sign        = sign_q;
  assign zflag       = zflag_q;

endmodule
